// File: rtl/bitwise_logic_unit_if.sv
// ---------------------------------------------------------------------------
// bitwise_logic_unit_if
//
// Purpose:
//   Bundles the operand-side and result-side handshake signals of the
//   bitwise logic unit. Signal names are kept identical to the unit's
//   port list so that the direction of each signal is readable at the
//   point of use.
//
// Parameters:
//   WIDTH   - operand/result width in bits
//   COUNT_W - width of the accepted-transfer counter
//
// Signals:
//   i_valid, i_op, i_op1, i_op2, i_acc_sel, i_acc_clr - operand source side
//   o_ready                                             - unit can accept
//   o_valid, o_res, o_zero, o_ones, o_count             - result side
//   i_ready                                             - sink accepts result
//
// Modports:
//   slave  - the logic unit itself
//   master - the surrounding environment (operand source plus result sink)
// ---------------------------------------------------------------------------
interface bitwise_logic_unit_if #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 8
);
    logic               i_valid;
    logic               o_ready;
    logic [2:0]         i_op;
    logic [WIDTH-1:0]   i_op1;
    logic [WIDTH-1:0]   i_op2;
    logic               i_acc_sel;
    logic               i_acc_clr;
    logic               o_valid;
    logic               i_ready;
    logic [WIDTH-1:0]   o_res;
    logic               o_zero;
    logic               o_ones;
    logic [COUNT_W-1:0] o_count;

    modport slave (
        input  i_valid,
        input  i_op,
        input  i_op1,
        input  i_op2,
        input  i_acc_sel,
        input  i_acc_clr,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_res,
        output o_zero,
        output o_ones,
        output o_count
    );

    modport master (
        output i_valid,
        output i_op,
        output i_op1,
        output i_op2,
        output i_acc_sel,
        output i_acc_clr,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_res,
        input  o_zero,
        input  o_ones,
        input  o_count
    );
endinterface

// File: rtl/bitwise_logic_unit.sv
// ---------------------------------------------------------------------------
// bitwise_logic_unit
//
// Purpose:
//   Registered bitwise logic unit with a valid/ready handshake. Each accepted
//   transfer applies one of eight per-bit operations to two WIDTH-bit
//   operands and places the result in a one-entry output register that the
//   sink drains with i_ready. Full throughput (one transfer per cycle) is
//   kept while the sink is ready.
//
//   Op encoding: 000 A&B, 001 A|B, 010 A^B, 011 ~(A|B),
//                100 ~(A&B), 101 ~(A^B), 110 ~A, 111 A
//
// Build option:
//   BITWISE_LU_ACC_EN - when defined, an accumulator register is built that
//                       captures every accepted result; i_acc_sel selects it
//                       as operand A and i_acc_clr clears it. When undefined
//                       both inputs are ignored and operand A is i_op1.
//
// Ports:
//   i_clk - clock, rising edge
//   i_rst - asynchronous reset, active high
//   bus   - bitwise_logic_unit_if.slave (operands, op, handshake, result,
//           zero/all-ones flags and accepted-transfer count)
// ---------------------------------------------------------------------------
module bitwise_logic_unit #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 8
) (
    input logic                 i_clk,
    input logic                 i_rst,
    bitwise_logic_unit_if.slave bus
);

    logic               ready;
    logic               accept;
    logic [WIDTH-1:0]   operand_a;
    logic [WIDTH-1:0]   result;
    logic               valid_q;
    logic [WIDTH-1:0]   res_q;
    logic               zero_q;
    logic               ones_q;
    logic [COUNT_W-1:0] count_q;

    // The output register can take a new result when it is empty or when
    // its current content leaves this very cycle; i_valid is deliberately
    // kept out of this path.
    assign ready  = !valid_q || bus.i_ready;
    assign accept = bus.i_valid && ready;

`ifdef BITWISE_LU_ACC_EN
    logic [WIDTH-1:0] acc_q;

    assign operand_a = bus.i_acc_sel ? acc_q : bus.i_op1;

    // Accumulator captures every accepted result. Clear wins over a
    // same-cycle load, yet that accept still used the old value as
    // operand A because operand_a reads acc_q before the edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q <= '0;
        end else if (bus.i_acc_clr) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q <= result;
        end
    end
`else
    logic unused_acc_ports;

    assign unused_acc_ports = bus.i_acc_sel ^ bus.i_acc_clr;
    assign operand_a        = bus.i_op1;
`endif

    // Per-bit operation select; no carries, so the result is exactly WIDTH bits.
    always_comb begin
        result = '0;
        case (bus.i_op)
            3'b000: result = operand_a & bus.i_op2;
            3'b001: result = operand_a | bus.i_op2;
            3'b010: result = operand_a ^ bus.i_op2;
            3'b011: result = ~(operand_a | bus.i_op2);
            3'b100: result = ~(operand_a & bus.i_op2);
            3'b101: result = ~(operand_a ^ bus.i_op2);
            3'b110: result = ~operand_a;
            3'b111: result = operand_a;
        endcase
    end

    // One-entry output register. Result and flags only change on accept,
    // so they stay stable while the sink stalls. o_valid drops only when
    // the sink takes the result and nothing new arrives.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b1;
            ones_q  <= 1'b0;
            count_q <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            res_q   <= result;
            zero_q  <= (result == '0);
            ones_q  <= &result;
            count_q <= count_q + COUNT_W'(1);
        end else if (bus.i_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_valid = valid_q;
    assign bus.o_res   = res_q;
    assign bus.o_zero  = zero_q;
    assign bus.o_ones  = ones_q;
    assign bus.o_count = count_q;

endmodule
